// File: rtl/shunt_fringe_pkg.sv
// -----------------------------------------------------------------------------
// shunt_fringe_pkg
// Shared types and default widths for the shunt_fringe_if mailbox hub.
//   - reg_state_e : registration FSM states (UNREG -> WAIT -> REG)
//   - sig_entry_t : one signal-database entry {id, data_valid, ovf, payload}
//   - idx_w()     : index width for an N-entry table (never below 1 bit)
// Optional feature macro used by the hub: SHUNT_FRINGE_WATCHDOG_EN.
// -----------------------------------------------------------------------------
package shunt_fringe_pkg;

  localparam int DEF_NUM_SIG    = 4;
  localparam int DATA_W         = 9;     // {valid, data[7:0]} vectors
  localparam int ID_W           = 16;
  localparam int DEF_SIMID_W    = 8;
  localparam int DEF_TIME_W     = 32;
  localparam int DEF_REG_LAT    = 4;
  localparam int DEF_WDOG_LIMIT = 10000;

  typedef enum logic [1:0] {
    UNREG = 2'd0,
    WAIT  = 2'd1,
    REG   = 2'd2
  } reg_state_e;

  // Payload and ID widths are fixed by this struct, so they are package
  // constants rather than per-instance parameters.
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic              data_valid;
    logic              ovf;
    logic [DATA_W-1:0] payload;
  } sig_entry_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shunt_fringe_if_if.sv
// -----------------------------------------------------------------------------
// shunt_fringe_if_if
// Bus between the local agent (master) and the mailbox hub (slave).
//   cfg_*    : ID-table write port
//   lookup_* : combinational ID -> index resolution
//   put_*    : deposit strobe, index, payload
//   get_*    : consume strobe, index; get_valid/get_miss/get_data one cycle later
//   data_valid_o / ovf_o : per-entry status flags
//   err_o    : one-cycle pulse on an illegal put/get
// Handshake: put_i/get_i are single-cycle strobes with no back-pressure; the
// hub accepts every strobe on the clock edge it is seen, and every get
// produces exactly one of get_valid_o, get_miss_o or err_o on the next cycle.
// -----------------------------------------------------------------------------
interface shunt_fringe_if_if
  import shunt_fringe_pkg::*;
#(
  parameter int NUM_SIG = DEF_NUM_SIG
) ();

  localparam int IDX_W = idx_w(NUM_SIG);

  logic               cfg_we_i;
  logic [IDX_W-1:0]   cfg_idx_i;
  logic [ID_W-1:0]    cfg_id_i;
  logic [ID_W-1:0]    lookup_id_i;
  logic [IDX_W-1:0]   lookup_idx_o;
  logic               lookup_hit_o;
  logic               put_i;
  logic [IDX_W-1:0]   put_idx_i;
  logic [DATA_W-1:0]  put_data_i;
  logic               get_i;
  logic [IDX_W-1:0]   get_idx_i;
  logic               get_valid_o;
  logic               get_miss_o;
  logic [DATA_W-1:0]  get_data_o;
  logic [NUM_SIG-1:0] data_valid_o;
  logic [NUM_SIG-1:0] ovf_o;
  logic               err_o;

  modport master (
    output cfg_we_i, cfg_idx_i, cfg_id_i, lookup_id_i,
    output put_i, put_idx_i, put_data_i, get_i, get_idx_i,
    input  lookup_idx_o, lookup_hit_o, get_valid_o, get_miss_o, get_data_o,
    input  data_valid_o, ovf_o, err_o
  );

  modport slave (
    input  cfg_we_i, cfg_idx_i, cfg_id_i, lookup_id_i,
    input  put_i, put_idx_i, put_data_i, get_i, get_idx_i,
    output lookup_idx_o, lookup_hit_o, get_valid_o, get_miss_o, get_data_o,
    output data_valid_o, ovf_o, err_o
  );

endinterface

// File: rtl/shunt_fringe_lut.sv
// -----------------------------------------------------------------------------
// shunt_fringe_lut
// Combinational priority match of lookup_id_i against the ID table.
//   ids_i       : ID of every entry, entry 0 in the low slot
//   lookup_id_i : ID to resolve
//   idx_o       : lowest matching entry index (0 on miss)
//   hit_o       : at least one entry matched
// -----------------------------------------------------------------------------
module shunt_fringe_lut
  import shunt_fringe_pkg::*;
#(
  parameter int NUM_SIG = DEF_NUM_SIG,
  parameter int IDX_W   = idx_w(NUM_SIG)
) (
  input  logic [NUM_SIG-1:0][ID_W-1:0] ids_i,
  input  logic [ID_W-1:0]              lookup_id_i,
  output logic [IDX_W-1:0]             idx_o,
  output logic                         hit_o
);

  // Scan from the top down so the last assignment is the lowest match.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_SIG - 1; i >= 0; i--) begin
      if (ids_i[i] == lookup_id_i) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/shunt_fringe_if.sv
// -----------------------------------------------------------------------------
// shunt_fringe_if
// Co-simulation fringe mailbox hub: NUM_SIG-entry signal database with
// put/get by index, static ID table with priority lookup, one-shot agent
// registration and a free-running time counter.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   reg_req_i      : registration request, simid_i sampled with it
//   reg_ack_o      : one-cycle pulse when registration completes
//   registered_o   : sticky registered flag
//   simid_o        : latched simulation ID
//   time_o         : cycles since reset, wraps
//   reg_state_o    : registration FSM state (debug)
//   wdog_o         : sticky miss watchdog (only with SHUNT_FRINGE_WATCHDOG_EN)
//   bus            : shunt_fringe_if_if.slave (cfg/lookup/put/get/status)
// Optional feature macro: SHUNT_FRINGE_WATCHDOG_EN. When defined, a run of
// WDOG_LIMIT consecutive get misses sets wdog_o and blocks further gets.
// -----------------------------------------------------------------------------
module shunt_fringe_if
  import shunt_fringe_pkg::*;
#(
  parameter int NUM_SIG = DEF_NUM_SIG,
  parameter int SIMID_W = DEF_SIMID_W,
  parameter int TIME_W  = DEF_TIME_W,
  parameter int REG_LAT = DEF_REG_LAT
`ifdef SHUNT_FRINGE_WATCHDOG_EN
  , parameter int WDOG_LIMIT = DEF_WDOG_LIMIT
`endif
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               reg_req_i,
  input  logic [SIMID_W-1:0] simid_i,
  output logic               reg_ack_o,
  output logic               registered_o,
  output logic [SIMID_W-1:0] simid_o,
  output logic [TIME_W-1:0]  time_o,
  output reg_state_e         reg_state_o,
`ifdef SHUNT_FRINGE_WATCHDOG_EN
  output logic               wdog_o,
`endif
  shunt_fringe_if_if.slave   bus
);

  localparam int IDX_W = idx_w(NUM_SIG);
  localparam int LAT_W = $clog2(REG_LAT + 2);

  // ---------------------------------------------------------------------------
  // Time counter
  // ---------------------------------------------------------------------------
  logic [TIME_W-1:0] time_q, time_d;

  always_comb time_d = time_q + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) time_q <= '0;
    else       time_q <= time_d;
  end

  assign time_o = time_q;

  // ---------------------------------------------------------------------------
  // Registration FSM
  // ---------------------------------------------------------------------------
  reg_state_e         state_q, state_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic               ack_q, ack_d;
  logic               registered_q, registered_d;
  logic [SIMID_W-1:0] simid_q, simid_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ack_d        = 1'b0;
    registered_d = registered_q;
    simid_d      = simid_q;
    case (state_q)
      UNREG: begin
        if (reg_req_i) begin
          simid_d = simid_i;
          cnt_d   = LAT_W'(REG_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Ack lands on the edge where the count would reach zero, which puts
        // it exactly REG_LAT cycles after the request edge.
        if (cnt_q <= LAT_W'(1)) begin
          cnt_d        = '0;
          ack_d        = 1'b1;
          registered_d = 1'b1;
          state_d      = REG;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;  // REG is terminal until reset
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= UNREG;
      cnt_q        <= '0;
      ack_q        <= 1'b0;
      registered_q <= 1'b0;
      simid_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      registered_q <= registered_d;
      simid_q      <= simid_d;
    end
  end

  assign reg_ack_o    = ack_q;
  assign registered_o = registered_q;
  assign simid_o      = simid_q;
  assign reg_state_o  = state_q;

  // ---------------------------------------------------------------------------
  // Signal database
  // ---------------------------------------------------------------------------
  sig_entry_t        db_q [NUM_SIG];
  sig_entry_t        db_d [NUM_SIG];
  logic              get_valid_q, get_valid_d;
  logic              get_miss_q, get_miss_d;
  logic [DATA_W-1:0] get_data_q, get_data_d;
  logic              err_q, err_d;
  logic              put_ok, get_ok, same_idx, gets_blocked;

`ifdef SHUNT_FRINGE_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_LIMIT + 1);
  logic [WD_W-1:0] miss_cnt_q, miss_cnt_d;
  logic            wdog_q, wdog_d;

  assign gets_blocked = wdog_q;
`else
  assign gets_blocked = 1'b0;
`endif

  always_comb begin
    put_ok   = bus.put_i && registered_q && (int'(bus.put_idx_i) < NUM_SIG);
    get_ok   = bus.get_i && registered_q && (int'(bus.get_idx_i) < NUM_SIG)
               && !gets_blocked;
    same_idx = put_ok && get_ok && (bus.put_idx_i == bus.get_idx_i);

    for (int i = 0; i < NUM_SIG; i++) db_d[i] = db_q[i];
    get_valid_d = 1'b0;
    get_miss_d  = 1'b0;
    get_data_d  = get_data_q;
    err_d       = (bus.put_i && !put_ok) || (bus.get_i && !get_ok);

    // Get reads the pre-cycle entry; a same-entry put below then overrides
    // the cleared flag, so the put always wins the final state.
    if (get_ok) begin
      if (db_q[bus.get_idx_i].data_valid) begin
        get_valid_d                        = 1'b1;
        get_data_d                         = db_q[bus.get_idx_i].payload;
        db_d[bus.get_idx_i].data_valid     = 1'b0;
      end else begin
        get_miss_d = 1'b1;
      end
    end

    if (put_ok) begin
      // A same-cycle get drains the old value, so nothing is lost.
      if (db_q[bus.put_idx_i].data_valid && !same_idx)
        db_d[bus.put_idx_i].ovf = 1'b1;
      db_d[bus.put_idx_i].payload    = bus.put_data_i;
      db_d[bus.put_idx_i].data_valid = 1'b1;
    end

    // The ID table is static configuration and is writable before registration.
    if (bus.cfg_we_i && (int'(bus.cfg_idx_i) < NUM_SIG))
      db_d[bus.cfg_idx_i].id = bus.cfg_id_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_SIG; i++) db_q[i] <= '0;
      get_valid_q <= 1'b0;
      get_miss_q  <= 1'b0;
      get_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SIG; i++) db_q[i] <= db_d[i];
      get_valid_q <= get_valid_d;
      get_miss_q  <= get_miss_d;
      get_data_q  <= get_data_d;
      err_q       <= err_d;
    end
  end

`ifdef SHUNT_FRINGE_WATCHDOG_EN
  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (get_valid_d)
      miss_cnt_d = '0;
    else if (get_miss_d && (miss_cnt_q != WD_W'(WDOG_LIMIT)))
      miss_cnt_d = miss_cnt_q + 1'b1;
    wdog_d = wdog_q || (miss_cnt_d == WD_W'(WDOG_LIMIT));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      miss_cnt_q <= '0;
      wdog_q     <= 1'b0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
      wdog_q     <= wdog_d;
    end
  end

  assign wdog_o = wdog_q;
`endif

  // ---------------------------------------------------------------------------
  // Status flattening and lookup
  // ---------------------------------------------------------------------------
  logic [NUM_SIG-1:0][ID_W-1:0] ids;
  logic [NUM_SIG-1:0]           dv_flat, ovf_flat;
  logic [IDX_W-1:0]             lut_idx;
  logic                         lut_hit;

  always_comb begin
    for (int i = 0; i < NUM_SIG; i++) begin
      ids[i]      = db_q[i].id;
      dv_flat[i]  = db_q[i].data_valid;
      ovf_flat[i] = db_q[i].ovf;
    end
  end

  shunt_fringe_lut #(
    .NUM_SIG (NUM_SIG),
    .IDX_W   (IDX_W)
  ) u_lut (
    .ids_i       (ids),
    .lookup_id_i (bus.lookup_id_i),
    .idx_o       (lut_idx),
    .hit_o       (lut_hit)
  );

  assign bus.lookup_idx_o = lut_idx;
  assign bus.lookup_hit_o = lut_hit;
  assign bus.get_valid_o  = get_valid_q;
  assign bus.get_miss_o   = get_miss_q;
  assign bus.get_data_o   = get_data_q;
  assign bus.data_valid_o = dv_flat;
  assign bus.ovf_o        = ovf_flat;
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_shunt_fringe_if.sv
// -----------------------------------------------------------------------------
// tb_shunt_fringe_if
// Directed bench for the shunt_fringe_if mailbox hub: reset state, time
// counter, unregistered access, ID lookup, registration latency, put/get
// round trip, overwrite, same-cycle put/get, reset mid-operation.
// -----------------------------------------------------------------------------
module tb_shunt_fringe_if;
  import shunt_fringe_pkg::*;

  localparam int NUM_SIG = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        reg_req;
  logic [7:0]  simid;
  logic        reg_ack;
  logic        registered;
  logic [7:0]  simid_out;
  logic [31:0] time_val;
  reg_state_e  reg_state;
`ifdef SHUNT_FRINGE_WATCHDOG_EN
  logic        wdog;
`endif

  shunt_fringe_if_if #(.NUM_SIG(NUM_SIG)) bus ();

  shunt_fringe_if #(.NUM_SIG(NUM_SIG)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .reg_req_i    (reg_req),
    .simid_i      (simid),
    .reg_ack_o    (reg_ack),
    .registered_o (registered),
    .simid_o      (simid_out),
    .time_o       (time_val),
    .reg_state_o  (reg_state),
`ifdef SHUNT_FRINGE_WATCHDOG_EN
    .wdog_o       (wdog),
`endif
    .bus          (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    reg_req          = 1'b0;
    simid            = 8'h00;
    bus.cfg_we_i     = 1'b0;
    bus.cfg_idx_i    = '0;
    bus.cfg_id_i     = '0;
    bus.lookup_id_i  = '0;
    bus.put_i        = 1'b0;
    bus.put_idx_i    = '0;
    bus.put_data_i   = '0;
    bus.get_i        = 1'b0;
    bus.get_idx_i    = '0;
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [15:0] id);
    bus.cfg_we_i  = 1'b1;
    bus.cfg_idx_i = idx;
    bus.cfg_id_i  = id;
    tick();
    bus.cfg_we_i  = 1'b0;
  endtask

  task automatic put(input logic [1:0] idx, input logic [8:0] data);
    bus.put_i      = 1'b1;
    bus.put_idx_i  = idx;
    bus.put_data_i = data;
    tick();
    bus.put_i      = 1'b0;
  endtask

  task automatic get(input logic [1:0] idx);
    bus.get_i     = 1'b1;
    bus.get_idx_i = idx;
    tick();
    bus.get_i     = 1'b0;
  endtask

  task automatic put_get(input logic [1:0] pidx, input logic [8:0] data, input logic [1:0] gidx);
    bus.put_i      = 1'b1;
    bus.put_idx_i  = pidx;
    bus.put_data_i = data;
    bus.get_i      = 1'b1;
    bus.get_idx_i  = gidx;
    tick();
    bus.put_i      = 1'b0;
    bus.get_i      = 1'b0;
  endtask

  // Lookup table: {id, expected hit, expected index}
  logic [15:0] lk_id  [4] = '{16'h0020, 16'h0099, 16'h0030, 16'h0010};
  logic        lk_hit [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [1:0]  lk_idx [4] = '{2'd1, 2'd0, 2'd3, 2'd0};

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    idle_inputs();
    #1;
    check("rst_reg_ack",    32'(reg_ack), 32'd0);
    check("rst_registered", 32'(registered), 32'd0);
    check("rst_simid",      32'(simid_out), 32'd0);
    check("rst_time",       time_val, 32'd0);
    check("rst_state",      32'(reg_state), 32'(UNREG));
    check("rst_dv",         32'(bus.data_valid_o), 32'd0);
    check("rst_ovf",        32'(bus.ovf_o), 32'd0);
    check("rst_err",        32'(bus.err_o), 32'd0);
    check("rst_get_valid",  32'(bus.get_valid_o), 32'd0);
    check("rst_get_miss",   32'(bus.get_miss_o), 32'd0);
    check("rst_get_data",   32'(bus.get_data_o), 32'd0);
`ifdef SHUNT_FRINGE_WATCHDOG_EN
    check("rst_wdog",       32'(wdog), 32'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;

    // Time counter exactly 1001 cycles after reset release
    repeat (1001) tick();
    check("time_1001", time_val, 32'd1001);

    // Unregistered put -> error, no state change
    put(2'd2, 9'h055);
    check("unreg_put_err", 32'(bus.err_o), 32'd1);
    check("unreg_put_dv",  32'(bus.data_valid_o), 32'd0);
    get(2'd2);
    check("unreg_get_err",   32'(bus.err_o), 32'd1);
    check("unreg_get_valid", 32'(bus.get_valid_o), 32'd0);
    check("unreg_get_miss",  32'(bus.get_miss_o), 32'd0);
    tick();
    check("err_one_cycle", 32'(bus.err_o), 32'd0);

    // ID table and lookup
    cfg_write(2'd0, 16'h0010);
    cfg_write(2'd1, 16'h0020);
    cfg_write(2'd2, 16'h0020);
    cfg_write(2'd3, 16'h0030);
    for (int i = 0; i < 4; i++) begin
      bus.lookup_id_i = lk_id[i];
      #1;
      check($sformatf("lookup_hit_%0h", lk_id[i]), 32'(bus.lookup_hit_o), 32'(lk_hit[i]));
      check($sformatf("lookup_idx_%0h", lk_id[i]), 32'(bus.lookup_idx_o), 32'(lk_idx[i]));
    end

    // Registration: ack REG_LAT cycles after the request edge
    simid   = 8'h05;
    reg_req = 1'b1;
    tick();
    reg_req = 1'b0;
    simid   = 8'h77;
    check("reg_state_wait", 32'(reg_state), 32'(WAIT));
    check("reg_simid",      32'(simid_out), 32'h05);
    check("reg_ack_early0", 32'(reg_ack), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("reg_ack_early%0d", k), 32'(reg_ack), 32'd0);
      check($sformatf("reg_flag_early%0d", k), 32'(registered), 32'd0);
    end
    tick();
    check("reg_ack_pulse",  32'(reg_ack), 32'd1);
    check("reg_registered", 32'(registered), 32'd1);
    check("reg_state_reg",  32'(reg_state), 32'(REG));
    reg_req = 1'b1;
    tick();
    reg_req = 1'b0;
    check("reg_ack_drop",   32'(reg_ack), 32'd0);
    check("reg_req_ignored_simid", 32'(simid_out), 32'h05);
    check("reg_still_registered",  32'(registered), 32'd1);

    // Put/get round trip
    put(2'd3, 9'h1A5);
    check("rt_put_dv",  32'(bus.data_valid_o), 32'b1000);
    check("rt_put_err", 32'(bus.err_o), 32'd0);
    get(2'd3);
    check("rt_get_valid", 32'(bus.get_valid_o), 32'd1);
    check("rt_get_data",  32'(bus.get_data_o), 32'h1A5);
    check("rt_get_dv",    32'(bus.data_valid_o), 32'b0000);
    check("rt_get_miss",  32'(bus.get_miss_o), 32'd0);
    get(2'd3);
    check("rt_miss",       32'(bus.get_miss_o), 32'd1);
    check("rt_miss_valid", 32'(bus.get_valid_o), 32'd0);
    check("rt_miss_hold",  32'(bus.get_data_o), 32'h1A5);
    tick();
    check("rt_miss_pulse", 32'(bus.get_miss_o), 32'd0);

    // Overwrite
    put(2'd0, 9'h011);
    check("ow_first_ovf", 32'(bus.ovf_o), 32'b0000);
    put(2'd0, 9'h022);
    check("ow_ovf", 32'(bus.ovf_o), 32'b0001);
    check("ow_dv",  32'(bus.data_valid_o), 32'b0001);
    get(2'd0);
    check("ow_get_data", 32'(bus.get_data_o), 32'h022);
    check("ow_ovf_sticky", 32'(bus.ovf_o), 32'b0001);

    // Same-cycle put/get, entry empty
    put_get(2'd1, 9'h0FF, 2'd1);
    check("sim_empty_miss", 32'(bus.get_miss_o), 32'd1);
    check("sim_empty_dv",   32'(bus.data_valid_o), 32'b0010);
    check("sim_empty_ovf",  32'(bus.ovf_o), 32'b0001);
    get(2'd1);
    check("sim_empty_get_valid", 32'(bus.get_valid_o), 32'd1);
    check("sim_empty_get_data",  32'(bus.get_data_o), 32'h0FF);

    // Same-cycle put/get, entry full: old value out, new value kept, no ovf
    put(2'd2, 9'h033);
    put_get(2'd2, 9'h044, 2'd2);
    check("sim_full_valid", 32'(bus.get_valid_o), 32'd1);
    check("sim_full_data",  32'(bus.get_data_o), 32'h033);
    check("sim_full_dv",    32'(bus.data_valid_o), 32'b0100);
    check("sim_full_ovf",   32'(bus.ovf_o), 32'b0001);
    get(2'd2);
    check("sim_full_next", 32'(bus.get_data_o), 32'h044);

    // Different entries in the same cycle
    put_get(2'd3, 9'h0AB, 2'd0);
    check("diff_miss", 32'(bus.get_miss_o), 32'd1);
    check("diff_dv",   32'(bus.data_valid_o), 32'b1000);
    check("diff_hold", 32'(bus.get_data_o), 32'h044);

    check("time_track", time_val, 32'(cyc));

    // Reset mid-operation clears everything including registration
    rst = 1'b1;
    #1;
    check("mid_rst_registered", 32'(registered), 32'd0);
    check("mid_rst_dv",         32'(bus.data_valid_o), 32'd0);
    check("mid_rst_ovf",        32'(bus.ovf_o), 32'd0);
    check("mid_rst_time",       time_val, 32'd0);
    check("mid_rst_simid",      32'(simid_out), 32'd0);
    check("mid_rst_state",      32'(reg_state), 32'(UNREG));
    @(posedge clk);
    #1;
    rst = 1'b0;
    put(2'd1, 9'h001);
    check("post_rst_put_err", 32'(bus.err_o), 32'd1);
    check("post_rst_dv",      32'(bus.data_valid_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
